// File: rtl/cmd_asm.sv
// -----------------------------------------------------------------------------
// cmd_asm -- SUMP command assembler.
//
// Collects the byte stream from the UART receiver into complete commands for
// the instruction decoder. A byte with bit 7 clear is a one-byte short command.
// A byte with bit 7 set is the opcode of a long command and is followed by four
// argument bytes, LSB first. Every complete command is presented as a one-cycle
// strobe together with its opcode and 32-bit argument (zero for short commands).
//
// Optional feature, enabled by defining the macro CMD_ASM_TIMEOUT_EN:
//   an inter-byte timeout drops a partially received long command after
//   TIMEOUT_CYCLES idle cycles so the stream can resynchronise.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles tolerated between argument bytes (>= 2);
//                   only meaningful with CMD_ASM_TIMEOUT_EN.
//
// Ports:
//   clk_i      in   1   clock (single domain)
//   rst_i      in   1   synchronous, active-high reset
//   rx_stb_i   in   1   one-cycle strobe, rx_data_i holds a received byte
//   rx_data_i  in   8   received byte
//   stb_o      out  1   one-cycle pulse, a complete command is on opc_o/cmd_o
//   opc_o      out  8   opcode of the last completed command
//   cmd_o      out 32   argument of the last completed command
//   busy_o     out  1   a long command is partially received
//   tout_o     out  1   one-cycle pulse when a partial command is dropped
// -----------------------------------------------------------------------------
module cmd_asm #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_stb_i,
    input  logic [7:0]  rx_data_i,
    output logic        stb_o,
    output logic [7:0]  opc_o,
    output logic [31:0] cmd_o,
    output logic        busy_o,
    output logic        tout_o
);

    // Reject configurations the timeout counter cannot express.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("cmd_asm: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ARGS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;        // next argument byte position
    logic [7:0]  opc_sh_q, opc_sh_d;  // opcode of the command being assembled
    logic [31:0] arg_q, arg_d;        // argument shadow, built byte by byte
    logic [7:0]  opc_q, opc_d;        // published opcode
    logic [31:0] cmd_q, cmd_d;        // published argument
    logic        stb_q, stb_d;

`ifdef CMD_ASM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opc_sh_d = opc_sh_q;
        arg_d    = arg_q;
        opc_d    = opc_q;
        cmd_d    = cmd_q;
        stb_d    = 1'b0;
`ifdef CMD_ASM_TIMEOUT_EN
        tout_d   = 1'b0;
        cnt_d    = '0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (rx_stb_i) begin
                    opc_sh_d = rx_data_i;
                    if (!rx_data_i[7]) begin
                        // Short command: publish immediately with a zero argument.
                        opc_d = rx_data_i;
                        cmd_d = '0;
                        stb_d = 1'b1;
                    end else begin
                        arg_d   = '0;
                        idx_d   = 2'd0;
                        state_d = S_ARGS;
                    end
                end
            end

            S_ARGS: begin
                // Any byte here is argument data, even one with bit 7 set. A byte
                // arriving in the cycle the timeout would expire still wins.
                if (rx_stb_i) begin
                    arg_d[8*idx_q +: 8] = rx_data_i;
                    if (idx_q == 2'd3) begin
                        // The last byte bypasses the shadow so the result is
                        // published on the very next edge.
                        opc_d   = opc_sh_q;
                        cmd_d   = {rx_data_i, arg_q[23:0]};
                        stb_d   = 1'b1;
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
`ifdef CMD_ASM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Drop the partial command; published outputs stay untouched.
                    tout_d  = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            opc_sh_q <= 8'h00;
            arg_q    <= 32'h0000_0000;
            opc_q    <= 8'h00;
            cmd_q    <= 32'h0000_0000;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opc_sh_q <= opc_sh_d;
            arg_q    <= arg_d;
            opc_q    <= opc_d;
            cmd_q    <= cmd_d;
            stb_q    <= stb_d;
        end
    end

`ifdef CMD_ASM_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign tout_o = tout_q;
`else
    assign tout_o = 1'b0;
`endif

    assign stb_o  = stb_q;
    assign opc_o  = opc_q;
    assign cmd_o  = cmd_q;
    assign busy_o = (state_q == S_ARGS);

endmodule
